// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side and decode-side signals of the instruction fetch controller.
// master is the controller's view; slave is the memory/decode environment's view.
interface imem_fetch_ctrl_if #(
   parameter int unsigned Width = 32
);
   logic             fetch_en;
   logic [Width-1:0] imem_addr;
   logic [Width-1:0] imem_instr;
   logic             redirect_valid;
   logic [Width-1:0] redirect_pc;
   logic             inst_valid;
   logic             inst_ready;
   logic [Width-1:0] inst_data;
   logic [Width-1:0] inst_pc;

   modport master (
      input  fetch_en, imem_instr, redirect_valid, redirect_pc, inst_ready,
      output imem_addr, inst_valid, inst_data, inst_pc
   );

   modport slave (
      output fetch_en, imem_instr, redirect_valid, redirect_pc, inst_ready,
      input  imem_addr, inst_valid, inst_data, inst_pc
   );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// PC register plus 2-entry {pc, instr} buffer between instruction memory and decode.
// Define IMEM_FETCH_BYPASS_EN to present a fetched word in the same cycle when the buffer is empty.
module imem_fetch_ctrl #(
   parameter int unsigned      Width    = 32,
   parameter logic [Width-1:0] RESET_PC = '0
) (
   input logic                 clk,
   input logic                 rst_n,
   imem_fetch_ctrl_if.master   bus
);

   logic [Width-1:0] pc_q;
   logic [Width-1:0] fifo_pc_q    [2];
   logic [Width-1:0] fifo_instr_q [2];
   logic             rd_ptr_q;
   logic             wr_ptr_q;
   logic [1:0]       count_q;
   logic [1:0]       count_d;

   logic head_valid;
   logic pop;
   logic fire;
   logic byp;
   logic push;

   always_comb begin
      head_valid = (count_q != 2'd0);
      // A redirect squashes the presented head, so it is never counted as consumed.
      pop  = head_valid && bus.inst_ready && !bus.redirect_valid;
      fire = bus.fetch_en && !bus.redirect_valid && ((count_q != 2'd2) || pop);
`ifdef IMEM_FETCH_BYPASS_EN
      byp  = rst_n && fire && !head_valid;
`else
      byp  = 1'b0;
`endif
      // A bypassed word taken by decode this cycle never enters the buffer.
      push = fire && !(byp && bus.inst_ready);

      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
      end else if (bus.redirect_valid) begin
         pc_q     <= {bus.redirect_pc[Width-1:2], 2'b00};
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
      end else begin
         if (fire) begin
            pc_q <= pc_q + Width'(4);
         end
         if (push) begin
            fifo_pc_q[wr_ptr_q]    <= pc_q;
            fifo_instr_q[wr_ptr_q] <= bus.imem_instr;
            wr_ptr_q               <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   // Outputs are forced to their reset values while rst_n is low.
   always_comb begin
      bus.imem_addr  = rst_n ? pc_q : RESET_PC;
      bus.inst_valid = rst_n && (head_valid || byp);
      bus.inst_data  = '0;
      bus.inst_pc    = '0;
      if (rst_n && head_valid) begin
         bus.inst_data = fifo_instr_q[rd_ptr_q];
         bus.inst_pc   = fifo_pc_q[rd_ptr_q];
      end else if (byp) begin
         bus.inst_data = bus.imem_instr;
         bus.inst_pc   = pc_q;
      end
   end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter: Width, 32, data/address width of PC and instruction.
REQ-002 Parameter: RESET_PC, 32'h0, PC value loaded on reset.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  synchronous, active-low reset.
REQ-005 Port: fetch_en  input  1  fetch permitted this cycle.
REQ-006 Port: imem_addr  output  Width  byte address to instruction memory; equals current PC.
REQ-007 Port: imem_instr  input  Width  combinational read data for imem_addr, same cycle.
REQ-008 Port: redirect_valid  input  1  branch/jump redirect request.
REQ-009 Port: redirect_pc  input  Width  redirect target byte address.
REQ-010 Port: inst_valid  output  1  inst_data/inst_pc valid toward decode.
REQ-011 Port: inst_ready  input  1  decode accepts head instruction.
REQ-012 Port: inst_data  output  Width  instruction word at buffer head.
REQ-013 Port: inst_pc  output  Width  byte address of inst_data.

Function
REQ-014 Block SHALL hold PC register and a 2-entry FIFO of {pc, instr} pairs.
REQ-015 Fetch fires in a cycle when fetch_en=1, redirect_valid=0, and (count<2 or pop this cycle).
REQ-016 On fetch fire, {PC, imem_instr} SHALL be pushed and PC SHALL advance by 4, wrapping modulo 2^Width (32'hFFFFFFFC -> 32'h0).
REQ-017 Pop SHALL occur when inst_valid=1 and inst_ready=1; head then advances next cycle.
REQ-018 inst_valid SHALL equal (count!=0); inst_data/inst_pc SHALL be the FIFO head; values SHALL hold stable while inst_valid=1 and inst_ready=0.
REQ-019 Simultaneous push and pop at count=2 SHALL keep count=2 with order preserved; at count=1 SHALL keep count=1.
REQ-020 Push and pop SHALL never overflow/underflow: no push at count=2 without pop; pop ignored at count=0.
REQ-021 redirect_valid=1 has priority over all: FIFO flushed (count<=0), PC <= {redirect_pc[Width-1:2], 2'b00}, no push, no pop counted that cycle.
REQ-022 Head presented in redirect cycle SHALL be treated as squashed even if inst_ready=1.
REQ-023 fetch_en=0 SHALL freeze PC; buffered entries still drain via handshake.
REQ-024 Fetch-to-inst_valid latency SHALL be 1 cycle (without REQ-030 macro).
REQ-025 Sustained throughput with inst_ready=1 and fetch_en=1 SHALL be one instruction per cycle.

Reset
REQ-026 On rising clk with rst_n=0: PC<=RESET_PC, count<=0, FIFO pointers<=0.
REQ-027 During and after reset cycle: inst_valid=0, inst_data=0, inst_pc=0, imem_addr=RESET_PC.
REQ-028 Reset asserted mid-stream SHALL discard all buffered entries; no pop/push occurs in that cycle.
REQ-029 First fetch after reset deassertion SHALL read RESET_PC.

Configuration
REQ-030 Macro IMEM_FETCH_BYPASS_EN: when defined and count=0 and fetch fires, inst_valid=1 same cycle with inst_data=imem_instr, inst_pc=PC; if inst_ready=1 the word is consumed and not pushed, else pushed.
REQ-031 Without IMEM_FETCH_BYPASS_EN, outputs come only from FIFO (registered, latency 1).
REQ-032 Bypass SHALL be suppressed in redirect cycles and in reset cycles.

Verification
REQ-033 Reset, mem[0]=32'h52324082, mem[4]=32'h4433C102, mem[8]=32'h4221C182, fetch_en=1, inst_ready=1 -> inst_pc 0,4,8 on consecutive cycles with matching inst_data, first valid 1 cycle after reset release.
REQ-034 inst_ready=0 for 5 cycles from reset -> count saturates at 2, PC stops at 8, inst_pc=0 stable; ready=1 -> 0,4,8,12 in order, no loss/duplication.
REQ-035 redirect_valid=1, redirect_pc=32'h103 while count=2 -> next cycle inst_valid=0, imem_addr=32'h100; following cycle inst_pc=32'h100.
REQ-036 redirect_pc=32'hFFFFFFF8 -> fetch sequence FFFFFFF8, FFFFFFFC, 0, 4.
REQ-037 rst_n=0 for one cycle with count=2 and inst_valid=1 -> inst_valid=0, imem_addr=RESET_PC next cycle.
REQ-038 IMEM_FETCH_BYPASS_EN defined, empty FIFO, ready=1 -> inst_pc=0 valid in first fetch cycle, count stays 0.
